// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the single-port RAM arbiter: FSM states, port IDs and default widths.
package ram_arbiter_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Combinational two-port grant: round-robin against the last owner, or fixed
// load/store priority on ties.
module rr_arbiter2
  import ram_arbiter_pkg::*;
(
  input  logic f_req,
  input  logic d_req,
  input  logic last_owner,
  input  logic data_priority,
  output logic grant_vld,
  output logic grant_port
);

  always_comb begin
    grant_vld  = f_req | d_req;
    grant_port = PORT_FETCH;
    if (f_req && d_req)
      grant_port = data_priority ? PORT_DATA : ~last_owner;
    else if (d_req)
      grant_port = PORT_DATA;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port registered-address RAM between instruction fetch and
// load/store, giving each a req/ack handshake with registered read data.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter bit DATA_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output logic              owner
);

  state_t state, next_state;

  logic              f_req_m, d_req_m;
  logic              gnt_vld, gnt_port;
  logic [ADDR_W-1:0] lat_addr_p0;
  logic              lat_we_p0;
  logic [DATA_W-1:0] lat_wdata_p0;

  // A port is not re-granted in the cycle its own ack is showing.
  assign f_req_m = f_req & ~f_ack;
  assign d_req_m = d_req & ~d_ack;

  rr_arbiter2 u_arb (
    .f_req         (f_req_m),
    .d_req         (d_req_m),
    .last_owner    (owner),
    .data_priority (DATA_PRIORITY),
    .grant_vld     (gnt_vld),
    .grant_port    (gnt_port)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (gnt_vld) next_state = ACCESS;
      ACCESS:  next_state = CAPTURE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Write strobe decoded from state so reset drops it without waiting for a clock.
  always_comb begin
    busy             = (state != IDLE);
    ram_write_enable = (state == ACCESS) && lat_we_p0;
  end

  assign ram_address = lat_addr_p0;
  assign ram_data    = lat_wdata_p0;

  // Grant stage: capture the winner's request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner        <= PORT_DATA;
      lat_addr_p0  <= '0;
      lat_we_p0    <= 1'b0;
      lat_wdata_p0 <= '0;
    end else if (state == IDLE && gnt_vld) begin
      owner        <= gnt_port;
      lat_addr_p0  <= (gnt_port == PORT_DATA) ? d_addr : f_addr;
      lat_we_p0    <= (gnt_port == PORT_DATA) && d_we;
      lat_wdata_p0 <= (gnt_port == PORT_DATA) ? d_wdata : '0;
    end
  end

  // Capture stage: RAM output is valid, register it and raise the owner's ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_ack   <= 1'b0;
      d_ack   <= 1'b0;
      f_rdata <= '0;
      d_rdata <= '0;
    end else begin
      f_ack <= (state == CAPTURE) && (owner == PORT_FETCH);
      d_ack <= (state == CAPTURE) && (owner == PORT_DATA);
      if (state == CAPTURE && owner == PORT_FETCH)
        f_rdata <= ram_out;
      if (state == CAPTURE && owner == PORT_DATA && !lat_we_p0)
        d_rdata <= ram_out;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: round-robin instance (dut0) and load/store-priority instance
// (dut1), each with its own registered-address RAM model.
module tb_ram_arbiter;

  localparam int DW = 16;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic          f_req0, d_req0, d_we0, f_ack0, d_ack0, ram_we0, busy0, owner0;
  logic [AW-1:0] f_addr0, d_addr0, ram_address0, aq0;
  logic [DW-1:0] d_wdata0, f_rdata0, d_rdata0, ram_data0, ram_out0;
  logic          f_req1, d_req1, d_we1, f_ack1, d_ack1, ram_we1, busy1, owner1;
  logic [AW-1:0] f_addr1, d_addr1, ram_address1, aq1;
  logic [DW-1:0] d_wdata1, f_rdata1, d_rdata1, ram_data1, ram_out1;

  logic          bd_we0, bd_we1;
  logic [AW-1:0] bd_addr0, bd_addr1;
  logic [DW-1:0] bd_data0, bd_data1;
  logic [DW-1:0] mem0 [0:255];
  logic [DW-1:0] mem1 [0:255];

  ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DATA_PRIORITY(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .f_req(f_req0), .f_addr(f_addr0), .f_ack(f_ack0), .f_rdata(f_rdata0),
    .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
    .d_ack(d_ack0), .d_rdata(d_rdata0),
    .ram_address(ram_address0), .ram_data(ram_data0),
    .ram_write_enable(ram_we0), .ram_out(ram_out0),
    .busy(busy0), .owner(owner0)
  );

  ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DATA_PRIORITY(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .f_req(f_req1), .f_addr(f_addr1), .f_ack(f_ack1), .f_rdata(f_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_ack(d_ack1), .d_rdata(d_rdata1),
    .ram_address(ram_address1), .ram_data(ram_data1),
    .ram_write_enable(ram_we1), .ram_out(ram_out1),
    .busy(busy1), .owner(owner1)
  );

  // RAM models: address registered on the clock edge, data out the cycle after.
  always @(posedge clk) begin
    if (bd_we0)       mem0[bd_addr0]     <= bd_data0;
    else if (ram_we0) mem0[ram_address0] <= ram_data0;
    aq0 <= ram_address0;
  end
  assign ram_out0 = mem0[aq0];

  always @(posedge clk) begin
    if (bd_we1)       mem1[bd_addr1]     <= bd_data1;
    else if (ram_we1) mem1[ram_address1] <= ram_data1;
    aq1 <= ram_address1;
  end
  assign ram_out1 = mem1[aq1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_reqs();
    f_req0   = 1'($urandom_range(0, 1));
    d_req0   = 1'($urandom_range(0, 1));
    d_we0    = 1'($urandom_range(0, 1));
    f_addr0  = 8'($urandom);
    d_addr0  = 8'($urandom);
    d_wdata0 = 16'($urandom);
    f_req1   = 1'($urandom_range(0, 1));
    d_req1   = 1'($urandom_range(0, 1));
    d_we1    = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst = 1'b0;
    f_req0 = 0; f_addr0 = '0; d_req0 = 0; d_we0 = 0; d_addr0 = '0; d_wdata0 = '0;
    f_req1 = 0; f_addr1 = '0; d_req1 = 0; d_we1 = 0; d_addr1 = '0; d_wdata1 = '0;
    bd_we0 = 0; bd_addr0 = '0; bd_data0 = '0;
    bd_we1 = 0; bd_addr1 = '0; bd_data1 = '0;

    // Reset held with random request activity; preload RAMs meanwhile.
    rand_reqs();
    bd_we0 = 1; bd_addr0 = 8'h10; bd_data0 = 16'hBEEF;
    bd_we1 = 1; bd_addr1 = 8'h40; bd_data1 = 16'hAAAA;
    tick();
    rand_reqs();
    bd_addr0 = 8'h30; bd_data0 = 16'h5555;
    bd_addr1 = 8'h41; bd_data1 = 16'h5151;
    tick();
    bd_we0 = 0; bd_we1 = 0;
    for (int i = 0; i < 4; i++) begin
      rand_reqs();
      tick();
    end
    check("rst_f_ack",   32'(f_ack0), 32'd0);
    check("rst_d_ack",   32'(d_ack0), 32'd0);
    check("rst_wen",     32'(ram_we0), 32'd0);
    check("rst_busy",    32'(busy0), 32'd0);
    check("rst_f_rdata", 32'(f_rdata0), 32'd0);
    check("rst_d_rdata", 32'(d_rdata0), 32'd0);
    check("rst_addr",    32'(ram_address0), 32'd0);
    check("rst_data",    32'(ram_data0), 32'd0);
    check("rst_owner",   32'(owner0), 32'd1);
    check("rst_owner1",  32'(owner1), 32'd1);

    f_req0 = 0; d_req0 = 0; d_we0 = 0; f_req1 = 0; d_req1 = 0; d_we1 = 0;
    rst = 1'b1;
    tick(); tick(); tick();
    check("idle_busy", 32'(busy0), 32'd0);
    check("idle_busy1", 32'(busy1), 32'd0);

    // Single fetch read of 0x10.
    f_req0 = 1; f_addr0 = 8'h10;
    tick();
    check("fetch_busy_t1", 32'(busy0), 32'd1);
    check("fetch_addr_t1", 32'(ram_address0), 32'h10);
    check("fetch_wen_t1",  32'(ram_we0), 32'd0);
    tick();
    check("fetch_ack_t2",  32'(f_ack0), 32'd0);
    tick();
    check("fetch_ack_t3",  32'(f_ack0), 32'd1);
    check("fetch_rdata",   32'(f_rdata0), 32'hBEEF);
    check("fetch_owner",   32'(owner0), 32'd0);
    f_req0 = 0;
    tick();
    check("fetch_ack_t4",  32'(f_ack0), 32'd0);
    check("fetch_busy_t4", 32'(busy0), 32'd0);
    check("fetch_hold",    32'(f_rdata0), 32'hBEEF);

    // Data write 0x1234 to 0x20, then read it back.
    d_req0 = 1; d_we0 = 1; d_addr0 = 8'h20; d_wdata0 = 16'h1234;
    tick();
    check("wr_wen_t1",  32'(ram_we0), 32'd1);
    check("wr_addr_t1", 32'(ram_address0), 32'h20);
    check("wr_data_t1", 32'(ram_data0), 32'h1234);
    tick();
    check("wr_wen_t2",  32'(ram_we0), 32'd0);
    check("wr_ack_t2",  32'(d_ack0), 32'd0);
    tick();
    check("wr_ack_t3",  32'(d_ack0), 32'd1);
    check("wr_rdata_unchanged", 32'(d_rdata0), 32'd0);
    check("wr_mem",     32'(mem0[8'h20]), 32'h1234);
    d_req0 = 0;
    tick();
    d_req0 = 1; d_we0 = 0;
    tick(); tick(); tick();
    check("rd_ack_t3",  32'(d_ack0), 32'd1);
    check("rd_rdata",   32'(d_rdata0), 32'h1234);
    d_req0 = 0;
    tick();
    check("rd_ack_t4",  32'(d_ack0), 32'd0);

    // Round-robin contention: owner is data, so fetch goes first, then alternate.
    f_req0 = 1; f_addr0 = 8'h20;
    d_req0 = 1; d_we0 = 0; d_addr0 = 8'h10;
    for (int k = 0; k < 4; k++) begin
      tick(); tick();
      check("rr_noack_f", 32'(f_ack0), 32'd0);
      check("rr_noack_d", 32'(d_ack0), 32'd0);
      tick();
      check("rr_f_ack", 32'(f_ack0), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_d_ack", 32'(d_ack0), (k % 2 == 0) ? 32'd0 : 32'd1);
      if (k % 2 == 0) check("rr_f_rdata", 32'(f_rdata0), 32'h1234);
      else            check("rr_d_rdata", 32'(d_rdata0), 32'hBEEF);
    end
    f_req0 = 0; d_req0 = 0;
    tick();
    check("rr_busy_end", 32'(busy0), 32'd0);

    // Priority instance: every fresh tie goes to load/store.
    for (int r = 0; r < 4; r++) begin
      f_req1 = 1; f_addr1 = 8'h40;
      d_req1 = 1; d_we1 = 0; d_addr1 = 8'h41;
      tick(); tick(); tick();
      check("pri_d_ack",  32'(d_ack1), 32'd1);
      check("pri_f_ack",  32'(f_ack1), 32'd0);
      check("pri_rdata",  32'(d_rdata1), 32'h5151);
      check("pri_owner",  32'(owner1), 32'd1);
      f_req1 = 0; d_req1 = 0;
      tick();
    end
    f_req1 = 1;
    tick(); tick(); tick();
    check("pri_fetch_ack",   32'(f_ack1), 32'd1);
    check("pri_fetch_rdata", 32'(f_rdata1), 32'hAAAA);
    check("pri_fetch_owner", 32'(owner1), 32'd0);
    f_req1 = 0;
    tick();

    // Reset during the ACCESS cycle of a write to 0x30.
    d_req0 = 1; d_we0 = 1; d_addr0 = 8'h30; d_wdata0 = 16'hDEAD;
    tick();
    check("abort_wen_pre", 32'(ram_we0), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_wen_async", 32'(ram_we0), 32'd0);
    check("abort_busy",      32'(busy0), 32'd0);
    tick();
    check("abort_mem",   32'(mem0[8'h30]), 32'h5555);
    check("abort_d_ack", 32'(d_ack0), 32'd0);
    d_req0 = 0;
    rst = 1'b1;
    tick();
    check("abort_d_ack_post", 32'(d_ack0), 32'd0);
    check("abort_busy_post",  32'(busy0), 32'd0);
    d_req0 = 1;
    tick(); tick(); tick();
    check("retry_d_ack", 32'(d_ack0), 32'd1);
    check("retry_mem",   32'(mem0[8'h30]), 32'hDEAD);
    d_req0 = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the CPU's single-port 256x16 data RAM.
- Shares the RAM between the instruction-fetch unit (read-only) and the load/store unit (read/write).
- Sequences the RAM's registered-address read timing so that each requester sees a simple req/ack handshake with registered read data.
- Sits between the CPU core and the RAM instance.

Parameters:
DATA_W, 16, RAM word width
ADDR_W, 8, RAM address width (256 words)
DATA_PRIORITY, 0, 0 = round-robin on ties; 1 = load/store port always wins ties

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
f_req  input  1  fetch request; held until f_ack
f_addr  input  ADDR_W  fetch address; stable while f_req
f_ack  output  1  one-cycle completion pulse for fetch
f_rdata  output  DATA_W  fetch read data; valid while f_ack
d_req  input  1  load/store request; held until d_ack
d_we  input  1  1 = write, 0 = read; stable while d_req
d_addr  input  ADDR_W  load/store address
d_wdata  input  DATA_W  write data
d_ack  output  1  one-cycle completion pulse for load/store
d_rdata  output  DATA_W  load read data; valid while d_ack (don't-care for writes)
ram_address  output  ADDR_W  to RAM address
ram_data  output  DATA_W  to RAM write data
ram_write_enable  output  1  to RAM write enable
ram_out  input  DATA_W  from RAM read data (address registered inside RAM; data valid the cycle after the address edge)
busy  output  1  high in any state other than IDLE
owner  output  1  0 = fetch, 1 = load/store; port of current or most recent grant

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE.
  - f_ack, d_ack, ram_write_enable, busy = 0.
  - f_rdata, d_rdata, ram_address, ram_data = 0.
  - owner = 1, so the first round-robin tie goes to fetch.
- FSM states:
  - IDLE: if any unmasked request is present, arbitrate and latch the winner's addr, we and wdata into internal registers. Set owner, go to ACCESS.
  - ACCESS (exactly 1 cycle): ram_address = latched addr. ram_write_enable = latched we (always 0 for fetch). ram_data = latched wdata. Go to CAPTURE.
  - CAPTURE (exactly 1 cycle): ram_write_enable = 0. For a read, ram_out is valid; register it into f_rdata or d_rdata per owner. Set the owner's ack register. Go to IDLE.
- ram_write_enable is decoded from state == ACCESS, so it is never high outside ACCESS.
- Latency: request sampled in cycle T (IDLE) -> ACCESS in T+1 -> CAPTURE in T+2 -> ack and rdata in T+3. The same latency applies to reads and writes.
- Throughput: one access per 3 cycles. A new grant may be taken in the ack cycle (IDLE).
- Masking: in the cycle a port's ack is high, that port's req is ignored. The other port may be granted in the same cycle.
- Arbitration:
  - Only one request: grant it.
  - Both requests, DATA_PRIORITY = 0: grant the port that is not owner (alternation).
  - Both requests, DATA_PRIORITY = 1: grant load/store.
- rdata registers hold their value until the next read captured for that port. Writes do not update d_rdata.
- Requests arriving while busy are not lost. The requester holds req, and it is arbitrated at the next IDLE.
- A request dropped before grant is simply not serviced. Dropping req after grant is illegal; the access still completes and is acked.
- Reset mid-operation: the FSM returns to IDLE immediately and ram_write_enable drops asynchronously. A write in ACCESS whose clock edge has not yet occurred is not performed. No ack is issued for the aborted access.
- Simultaneous read and write of the same address from different ports are serialised in grant order. A read granted after a write returns the new data.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE = 2'd0, ACCESS = 2'd1, CAPTURE = 2'd2
  - port IDs: PORT_FETCH = 1'b0, PORT_DATA = 1'b1
  - DATA_W and ADDR_W defaults
- One natural sub-module, rr_arbiter2: a combinational two-input grant with round-robin/priority select. Its inputs are masked requests, last owner and DATA_PRIORITY; its outputs are a grant valid and a port ID.
- The FSM, latches and ack/rdata registers stay in ram_arbiter.

Test Plan:
- Reset: hold rst = 0 with random req activity -> all outputs 0, owner = 1. After release, with no req, busy stays 0.
- Single fetch read: preload RAM[0x10] = 0xBEEF, pulse f_req with f_addr = 0x10 at T -> ram_address = 0x10 at T+1. At T+3, f_ack = 1 and f_rdata = 0xBEEF for exactly one cycle.
- Write then read on data port: d_we = 1, d_addr = 0x20, d_wdata = 0x1234 -> ram_write_enable high only in T+1 and d_ack at T+3. A following read of 0x20 returns d_rdata = 0x1234 at its T+3.
- Contention, DATA_PRIORITY = 0: f_req and d_req both held from T -> grants alternate fetch, data, fetch, data. Acks fall at T+3, T+6, T+9, T+12; no port is starved.
- Contention, DATA_PRIORITY = 1: both held for 4 accesses -> the data port wins every tie. Fetch is served only when d_req is low.
- Reset during ACCESS of a write to 0x30 (old value 0x5555): assert rst before the ACCESS edge -> RAM[0x30] stays 0x5555, no d_ack, FSM in IDLE. After release, a re-request completes normally.
